capture_bank_ctrl: RTL and testbench

//  Write-side controller for the spectrogram sample store: N-bank successor of the 2-bank ping-pong writer.

---
 rtl/capture_bank_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_capture_bank_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_bank_ctrl.sv
// capture_bank_ctrl
//
// Write-side controller for the spectrogram sample store. It generalises the
// old two-bank ping-pong writer to NUM_BANKS = 2**BANK_W banks of DEPTH words.
//
// While signal_detected is high the controller streams RAM write addresses
// {cur_bank, idx} into the current bank. When a bank holds DEPTH words it is
// handed to the reader (its bank_busy bit is set) and capture moves on to the
// next bank. A bank stays busy until the reader frees it with bank_release.
// If the next bank is still busy, capture stalls. Every sample offered while
// stalled is dropped and counted, and overflow is raised.
//
// Ports
//   clk                    clock; all state changes on the rising edge
//   reset                  asynchronous, active-high
//   signal_detected        capture request (level)
//   bank_release           1-cycle pulse: the reader is done with release_bank
//   release_bank           bank freed by bank_release
//   we                     RAM write strobe (combinational)
//   addr_in                RAM write address {cur_bank, idx}
//   bank_full              1-cycle pulse: full_bank holds DEPTH valid words
//   full_bank              bank reported by bank_full
//   memorization_completed 1-cycle pulse while the FSM is in DONE
//   final_bank             bank holding the last sample of the capture
//   idx_final              index of the last sample written
//   bank_busy              ownership vector; bit b set = bank b owned by the reader
//   overflow               sticky flag: samples dropped since reset
//   drop_cnt               saturating count of dropped samples
//   state                  IDLE=0 WRITE=1 DONE=2 STALL=3
module capture_bank_ctrl #(
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 200,
  parameter int BANK_W = 1,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    signal_detected,
  input  logic                    bank_release,
  input  logic [BANK_W-1:0]       release_bank,
  output logic                    we,
  output logic [BANK_W+IDX_W-1:0] addr_in,
  output logic                    bank_full,
  output logic [BANK_W-1:0]       full_bank,
  output logic                    memorization_completed,
  output logic [BANK_W-1:0]       final_bank,
  output logic [IDX_W-1:0]        idx_final,
  output logic [(2**BANK_W)-1:0]  bank_busy,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic [1:0]              state
);

  localparam int NUM_BANKS = 2**BANK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // A bank must hold at least two words, and the index must be able to address all of them.
  generate
    if (DEPTH < 2 || DEPTH > (2**IDX_W)) begin : g_bad_depth
      $error("capture_bank_ctrl: DEPTH must satisfy 2 <= DEPTH <= 2**IDX_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t                state_q,      state_d;
  logic [BANK_W-1:0]     cur_bank_q,   cur_bank_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic [BANK_W-1:0]     last_bank_q,  last_bank_d;
  logic [IDX_W-1:0]      last_idx_q,   last_idx_d;
  logic                  dirty_q,      dirty_d;
  logic                  bank_full_q,  bank_full_d;
  logic [BANK_W-1:0]     full_bank_q,  full_bank_d;
  logic [BANK_W-1:0]     final_bank_q, final_bank_d;
  logic [IDX_W-1:0]      idx_final_q,  idx_final_d;
  logic                  overflow_q,   overflow_d;
  logic [DROP_W-1:0]     drop_cnt_q,   drop_cnt_d;
  logic [NUM_BANKS-1:0]  bank_busy_q,  bank_busy_d;

  logic [NUM_BANKS-1:0]  busy_set;
  logic [NUM_BANKS-1:0]  busy_clr;
  logic [BANK_W-1:0]     next_bank;

  assign next_bank = cur_bank_q + BANK_W'(1);

  // Ownership bits. If a bank is set and released in the same cycle, the set
  // wins, so a freshly handed-over bank is never lost.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_busy
      assign busy_clr[gi]    = bank_release && (release_bank == BANK_W'(gi));
      assign bank_busy_d[gi] = busy_set[gi] | (bank_busy_q[gi] & ~busy_clr[gi]);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cur_bank_d   = cur_bank_q;
    idx_d        = idx_q;
    last_bank_d  = last_bank_q;
    last_idx_d   = last_idx_q;
    dirty_d      = dirty_q;
    bank_full_d  = 1'b0;
    full_bank_d  = full_bank_q;
    final_bank_d = final_bank_q;
    idx_final_d  = idx_final_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    busy_set     = '0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (signal_detected) begin
          state_d = bank_busy_q[cur_bank_q] ? S_STALL : S_WRITE;
        end
      end

      S_WRITE: begin
        if (signal_detected) begin
          last_bank_d = cur_bank_q;
          last_idx_d  = idx_q;
          dirty_d     = 1'b1;
          if (idx_q == LAST_IDX) begin
            // The bank is complete. Hand it to the reader and move to the next bank.
            idx_d              = '0;
            busy_set[cur_bank_q] = 1'b1;
            bank_full_d        = 1'b1;
            full_bank_d        = cur_bank_q;
            dirty_d            = 1'b0;
            cur_bank_d         = next_bank;
            if (bank_busy_q[next_bank]) begin
              state_d = S_STALL;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          // Latch the report on entry to DONE so that it is valid together with the completion pulse.
          state_d      = S_DONE;
          final_bank_d = last_bank_q;
          idx_final_d  = last_idx_q;
        end
      end

      S_DONE: begin
        // A partly filled bank still holds samples the reader must collect.
        if (dirty_q) begin
          busy_set[cur_bank_q] = 1'b1;
          cur_bank_d         = next_bank;
          dirty_d            = 1'b0;
        end
        idx_d   = '0;
        state_d = S_IDLE;
      end

      S_STALL: begin
        if (signal_detected) begin
          overflow_d = 1'b1;
          if (drop_cnt_q != {DROP_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
          end
        end
        if (!bank_busy_q[cur_bank_q]) begin
          idx_d   = '0;
          state_d = signal_detected ? S_WRITE : S_IDLE;
        end else if (!signal_detected) begin
          // Capture ended while blocked. Report the last sample actually written.
          state_d      = S_DONE;
          final_bank_d = last_bank_q;
          idx_final_d  = last_idx_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_bank_q   <= '0;
      idx_q        <= '0;
      last_bank_q  <= '0;
      last_idx_q   <= '0;
      dirty_q      <= 1'b0;
      bank_full_q  <= 1'b0;
      full_bank_q  <= '0;
      final_bank_q <= '0;
      idx_final_q  <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      bank_busy_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_bank_q   <= cur_bank_d;
      idx_q        <= idx_d;
      last_bank_q  <= last_bank_d;
      last_idx_q   <= last_idx_d;
      dirty_q      <= dirty_d;
      bank_full_q  <= bank_full_d;
      full_bank_q  <= full_bank_d;
      final_bank_q <= final_bank_d;
      idx_final_q  <= idx_final_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      bank_busy_q  <= bank_busy_d;
    end
  end

  assign we                     = (state_q == S_WRITE) && signal_detected;
  assign memorization_completed = (state_q == S_DONE);
  assign addr_in                = {cur_bank_q, idx_q};
  assign bank_full              = bank_full_q;
  assign full_bank              = full_bank_q;
  assign final_bank             = final_bank_q;
  assign idx_final              = idx_final_q;
  assign bank_busy              = bank_busy_q;
  assign overflow               = overflow_q;
  assign drop_cnt               = drop_cnt_q;
  assign state                  = state_q;

endmodule

// File: tb/tb_capture_bank_ctrl.sv
// Testbench for capture_bank_ctrl. It uses directed scenarios with
// hand-computed expectations. One instance has the default parameters
// (2 banks). A second instance has BANK_W=2 (4 banks).
module tb_capture_bank_ctrl;

  logic        clk;
  logic        reset;
  logic        sig;
  logic        rel;
  logic [1:0]  rel_bank;

  // default instance (BANK_W=1)
  logic        we, bank_full, comp, overflow;
  logic [8:0]  addr_in;
  logic [0:0]  full_bank, final_bank;
  logic [7:0]  idx_final;
  logic [1:0]  bank_busy, state;
  logic [15:0] drop_cnt;

  // four-bank instance (BANK_W=2)
  logic        we4, bank_full4, comp4, overflow4;
  logic [9:0]  addr_in4;
  logic [1:0]  full_bank4, final_bank4;
  logic [7:0]  idx_final4;
  logic [3:0]  bank_busy4;
  logic [1:0]  state4;
  logic [15:0] drop_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  capture_bank_ctrl dut (
    .clk(clk), .reset(reset), .signal_detected(sig),
    .bank_release(rel), .release_bank(rel_bank[0:0]),
    .we(we), .addr_in(addr_in), .bank_full(bank_full), .full_bank(full_bank),
    .memorization_completed(comp), .final_bank(final_bank), .idx_final(idx_final),
    .bank_busy(bank_busy), .overflow(overflow), .drop_cnt(drop_cnt), .state(state)
  );

  capture_bank_ctrl #(.IDX_W(8), .DEPTH(200), .BANK_W(2), .DROP_W(16)) dut4 (
    .clk(clk), .reset(reset), .signal_detected(sig),
    .bank_release(rel), .release_bank(rel_bank),
    .we(we4), .addr_in(addr_in4), .bank_full(bank_full4), .full_bank(full_bank4),
    .memorization_completed(comp4), .final_bank(final_bank4), .idx_final(idx_final4),
    .bank_busy(bank_busy4), .overflow(overflow4), .drop_cnt(drop_cnt4), .state(state4)
  );

  always #5 clk = ~clk;

  // Passive monitors. They only record what each DUT did; expected values are constants below.
  int         m_wr, m_full, m_comp;
  logic [9:0] m_first, m_last;
  logic [1:0] m_fb [4];
  logic [9:0] m_fa [4];

  always @(negedge clk) begin
    if (reset) begin
      m_wr <= 0; m_full <= 0; m_comp <= 0; m_first <= '0; m_last <= '0;
    end else begin
      if (bank_full) begin
        if (m_full < 4) begin
          m_fb[m_full] <= {1'b0, full_bank};
          m_fa[m_full] <= m_last;
        end
        m_full <= m_full + 1;
      end
      if (we) begin
        if (m_wr == 0) m_first <= {1'b0, addr_in};
        m_last <= {1'b0, addr_in};
        m_wr   <= m_wr + 1;
      end
      if (comp) m_comp <= m_comp + 1;
    end
  end

  int         m4_wr, m4_full;
  logic [9:0] m4_last;
  logic [1:0] m4_fb [4];
  logic [9:0] m4_fa [4];

  always @(negedge clk) begin
    if (reset) begin
      m4_wr <= 0; m4_full <= 0; m4_last <= '0;
    end else begin
      if (bank_full4) begin
        if (m4_full < 4) begin
          m4_fb[m4_full] <= full_bank4;
          m4_fa[m4_full] <= m4_last;
        end
        m4_full <= m4_full + 1;
      end
      if (we4) begin
        m4_last <= addr_in4;
        m4_wr   <= m4_wr + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge. Any release pulse lasts for exactly one edge.
  task automatic step();
    @(posedge clk);
    #1;
    rel = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; sig = 1'b0; rel = 1'b0; rel_bank = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  // Hold signal_detected high across n rising edges. With auto_rel set, each
  // bank_full from the selected instance is answered with a prompt release.
  task automatic run_sig(input int n, input bit auto_rel, input bit use4);
    sig = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (auto_rel && (use4 ? bank_full4 : bank_full)) begin
        rel      = 1'b1;
        rel_bank = use4 ? full_bank4 : {1'b0, full_bank};
      end
    end
    sig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit use4);
    for (int i = 0; i < 20; i++) begin
      if (use4 ? comp4 : comp) break;
      step();
    end
    check_val(tag, {31'd0, (use4 ? comp4 : comp)}, 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    apply_reset();

    // reset state
    check_val("rst_state", state, 0);
    check_val("rst_we", we, 0);
    check_val("rst_addr", addr_in, 0);
    check_val("rst_busy", bank_busy, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_drop", drop_cnt, 0);
    check_val("rst_full", bank_full, 0);
    check_val("rst_comp", comp, 0);
    check_val("rst_fidx", idx_final, 0);
    $display("[tb] reset: state=%0d busy=%b", state, bank_busy);

    // T1: ten writes
    run_sig(11, 1'b0, 1'b0);
    wait_done("t1_done", 1'b0);
    check_val("t1_fbank", final_bank, 0);
    check_val("t1_fidx", idx_final, 9);
    step();
    check_val("t1_busy", bank_busy, 2'b01);
    check_val("t1_state", state, 0);
    check_val("t1_wr", m_wr, 10);
    check_val("t1_first", m_first, 10'h000);
    check_val("t1_last", m_last, 10'h009);
    check_val("t1_ncomp", m_comp, 1);
    check_val("t1_nfull", m_full, 0);
    $display("[tb] T1: writes=%0d first=%0h last=%0h idx_final=%0d", m_wr, m_first, m_last, idx_final);

    // T2: 450 writes with prompt releases, wrapping back to bank 0
    apply_reset();
    run_sig(451, 1'b1, 1'b0);
    wait_done("t2_done", 1'b0);
    check_val("t2_fbank", final_bank, 0);
    check_val("t2_fidx", idx_final, 49);
    check_val("t2_ovf", overflow, 0);
    step();
    check_val("t2_nfull", m_full, 2);
    check_val("t2_fb0", m_fb[0], 0);
    check_val("t2_fa0", m_fa[0], 10'h0C7);
    check_val("t2_fb1", m_fb[1], 1);
    check_val("t2_fa1", m_fa[1], 10'h1C7);
    check_val("t2_wr", m_wr, 450);
    check_val("t2_last", m_last, 10'h031);
    check_val("t2_busy", bank_busy, 2'b01);
    $display("[tb] T2: writes=%0d fulls=%0d final=%0d/%0d", m_wr, m_full, final_bank, idx_final);

    // T3: no releases, so both banks fill and the last 100 samples are dropped
    apply_reset();
    run_sig(501, 1'b0, 1'b0);
    check_val("t3_stall", state, 3);
    check_val("t3_we", we, 0);
    check_val("t3_drop", drop_cnt, 100);
    check_val("t3_ovf", overflow, 1);
    wait_done("t3_done", 1'b0);
    check_val("t3_fbank", final_bank, 1);
    check_val("t3_fidx", idx_final, 199);
    step();
    check_val("t3_busy", bank_busy, 2'b11);
    check_val("t3_wr", m_wr, 400);
    check_val("t3_nfull", m_full, 2);
    $display("[tb] T3: writes=%0d drops=%0d final=%0d/%0d", m_wr, drop_cnt, final_bank, idx_final);

    // T4: a release during STALL resumes writing at 0x000 two cycles after the pulse
    apply_reset();
    sig = 1'b1;
    repeat (406) step();
    check_val("t4_stall", state, 3);
    check_val("t4_drop5", drop_cnt, 5);
    rel = 1'b1; rel_bank = 2'd0;
    step();
    check_val("t4_still", state, 3);
    check_val("t4_we0", we, 0);
    check_val("t4_busy", bank_busy, 2'b10);
    step();
    check_val("t4_resume", state, 1);
    check_val("t4_we1", we, 1);
    check_val("t4_addr0", addr_in, 9'h000);
    check_val("t4_drop7", drop_cnt, 7);
    repeat (10) step();
    check_val("t4_frozen", drop_cnt, 7);
    check_val("t4_addr10", addr_in, 9'h00A);
    sig = 1'b0;
    wait_done("t4_done", 1'b0);
    check_val("t4_fbank", final_bank, 0);
    check_val("t4_fidx", idx_final, 9);
    step();
    check_val("t4_busy_end", bank_busy, 2'b11);
    $display("[tb] T4: drops=%0d final=%0d/%0d busy=%b", drop_cnt, final_bank, idx_final, bank_busy);

    // T5: exactly one bank's worth of samples
    apply_reset();
    run_sig(201, 1'b0, 1'b0);
    check_val("t5_fullp", bank_full, 1);
    check_val("t5_fullb", full_bank, 0);
    wait_done("t5_done", 1'b0);
    check_val("t5_fbank", final_bank, 0);
    check_val("t5_fidx", idx_final, 199);
    step();
    check_val("t5_busy", bank_busy, 2'b01);
    check_val("t5_nfull", m_full, 1);
    $display("[tb] T5: writes=%0d final=%0d/%0d busy=%b", m_wr, final_bank, idx_final, bank_busy);

    // T6: reset in the middle of writing bank 1 at index 57
    sig = 1'b1;
    repeat (58) step();
    check_val("t6_addr", addr_in, 9'h139);
    check_val("t6_we", we, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_we_async", we, 0);
    check_val("t6_state", state, 0);
    check_val("t6_busy", bank_busy, 0);
    check_val("t6_addr_rst", addr_in, 0);
    sig = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    check_val("t6_nocomp", m_comp, 0);
    check_val("t6_idle", state, 0);
    $display("[tb] T6: aborted, state=%0d busy=%b", state, bank_busy);

    // T7: four-bank instance running the T2 stimulus
    apply_reset();
    run_sig(451, 1'b1, 1'b1);
    wait_done("t7_done", 1'b1);
    check_val("t7_fbank", final_bank4, 2);
    check_val("t7_fidx", idx_final4, 49);
    step();
    check_val("t7_nfull", m4_full, 2);
    check_val("t7_fb0", m4_fb[0], 0);
    check_val("t7_fa0", m4_fa[0], 10'h0C7);
    check_val("t7_fb1", m4_fb[1], 1);
    check_val("t7_fa1", m4_fa[1], 10'h1C7);
    check_val("t7_wr", m4_wr, 450);
    check_val("t7_last", m4_last, 10'h231);
    check_val("t7_busy", bank_busy4, 4'b0100);
    $display("[tb] T7: writes=%0d final=%0d/%0d busy=%b", m4_wr, final_bank4, idx_final4, bank_busy4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
